// File: rtl/map9v3_pkg.sv
// Shared types and constants for the map9v3 start-triggered LFSR sequencer.
package map9v3_pkg;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_RUN        = 3'd1,
    ST_ALMOSTDONE = 3'd2,
    ST_DONE       = 3'd3,
    ST_WAIT       = 3'd4
  } state_e;

  localparam logic [7:0] LFSR_SEED  = 8'h00;
  localparam logic [7:0] CNT_LOAD   = 8'hFF;
  localparam logic [1:0] START_EDGE = 2'b01;

endpackage

// File: rtl/map9v3_if.sv
// Bundle of the map9v3 request/result signals; the block owns the slave side.
interface map9v3_if;

  logic       start;
  logic [8:0] N;
  logic [8:0] dp;
  logic       done;
  logic [7:0] counter;
  logic [7:0] sr;

  modport master (
    output start, N,
    input  dp, done, counter, sr
  );

  modport slave (
    input  start, N,
    output dp, done, counter, sr
  );

endinterface

// File: rtl/map9v3_lfsr.sv
// Next-state function of the 8-bit XNOR LFSR (taps 7,5,4,3); all-zero is a legal seed.
module map9v3_lfsr (
  input  logic [7:0] sr_i,
  output logic [7:0] sr_next_o
);

  assign sr_next_o = {sr_i[6:0], ~(sr_i[7] ^ sr_i[5] ^ sr_i[4] ^ sr_i[3])};

endmodule

// File: rtl/map9v3.sv
// Start-triggered sequencer: clocks the LFSR until the down-counter meets N[7:0],
// then publishes {sr, N[8]} on dp and raises done.
module map9v3 (
  input  logic      clock,
  input  logic      reset,
  map9v3_if.slave   bus
);

  import map9v3_pkg::*;

  state_e     state_q, state_d, fsm_next_s;
  logic [1:0] startbuf_q;
  logic [7:0] counter_q, counter_d;
  logic [7:0] sr_q, sr_d;
  logic [8:0] dp_q, dp_d;
  logic       done_q, done_d;
  logic [7:0] sr_next_s;
  logic       restart_s;

  map9v3_lfsr u_lfsr (
    .sr_i      (sr_q),
    .sr_next_o (sr_next_s)
  );

  // A synchronised rising edge of start overrides whatever the FSM was doing.
  assign restart_s = (startbuf_q == START_EDGE);

  // Next-state and datapath updates for the current state.
  always_comb begin
    fsm_next_s = state_q;
    counter_d  = counter_q;
    sr_d       = sr_q;
    dp_d       = dp_q;
    done_d     = done_q;
    case (state_q)
      ST_INIT: begin
        counter_d  = CNT_LOAD;
        sr_d       = LFSR_SEED;
        done_d     = 1'b0;
        fsm_next_s = ST_RUN;
      end
      ST_RUN: begin
        sr_d      = sr_next_s;
        counter_d = counter_q - 8'd1;
        if (counter_q == bus.N[7:0]) begin
          fsm_next_s = ST_ALMOSTDONE;
        end else begin
          fsm_next_s = ST_RUN;
        end
      end
      ST_ALMOSTDONE: begin
        dp_d       = {sr_q, bus.N[8]};
        fsm_next_s = ST_DONE;
      end
      ST_DONE: begin
        done_d     = 1'b1;
        fsm_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        fsm_next_s = ST_WAIT;
      end
      default: begin
        fsm_next_s = ST_WAIT;
      end
    endcase
    state_d = restart_s ? ST_INIT : fsm_next_s;
  end

  // State, synchroniser and result registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_WAIT;
      startbuf_q <= 2'b00;
      counter_q  <= 8'h00;
      sr_q       <= 8'h00;
      dp_q       <= 9'h000;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      startbuf_q <= {startbuf_q[0], bus.start};
      counter_q  <= counter_d;
      sr_q       <= sr_d;
      dp_q       <= dp_d;
      done_q     <= done_d;
    end
  end

  assign bus.dp      = dp_q;
  assign bus.done    = done_q;
  assign bus.counter = counter_q;
  assign bus.sr      = sr_q;

endmodule

// File: tb/tb_map9v3.sv
// Randomised self-checking bench for map9v3 against a run-level reference model.
module tb_map9v3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   err_cnt = 0;
  int   chk_cnt = 0;
  logic [8:0] exp_dp = 9'h000;

  map9v3_if bus ();

  map9v3 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // LFSR state after k shifts from the zero seed, straight from the feedback rule.
  function automatic logic [7:0] lfsr_after(input int k);
    int s;
    int fb;
    s = 0;
    for (int i = 0; i < k; i++) begin
      fb = 1 - (((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1);
      s  = ((s << 1) & 255) | fb;
    end
    return s[7:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dp"},   32'(bus.dp),      32'd0);
    chk({tag, "_sr"},   32'(bus.sr),      32'd0);
    chk({tag, "_cnt"},  32'(bus.counter), 32'd0);
    chk({tag, "_done"}, 32'(bus.done),    32'd0);
  endtask

  // One full run: start held for 'pulse' sampled edges, then checks timing and result.
  task automatic run_check(input logic [8:0] n, input int pulse);
    int shifts;
    int cnt;
    bit seen;
    shifts = (n[7:0] == 8'd0) ? 256 : 256 - int'(n[7:0]);
    bus.N     = n;
    bus.start = 1'b1;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 300) begin
      tick();
      cnt++;
      if (cnt == pulse) bus.start = 1'b0;
      if (cnt == 3) begin
        chk("init_done",    32'(bus.done),    32'd0);
        chk("init_counter", 32'(bus.counter), 32'hFF);
        chk("init_sr",      32'(bus.sr),      32'd0);
        chk("init_dp_hold", 32'(bus.dp),      32'(exp_dp));
      end
      if (cnt == 3 + shifts) chk("dp_hold_pre", 32'(bus.dp), 32'(exp_dp));
      if (cnt > 3 && bus.done === 1'b1) seen = 1'b1;
    end
    bus.start = 1'b0;
    chk("latency", 32'(cnt - 1), 32'(shifts + 4));
    exp_dp = {lfsr_after(shifts), n[8]};
    chk("dp",      32'(bus.dp),      32'(exp_dp));
    chk("sr",      32'(bus.sr),      32'(lfsr_after(shifts)));
    chk("counter", 32'(bus.counter), 32'((int'(n[7:0]) + 255) % 256));
    repeat (4) tick();
    chk("done_held", 32'(bus.done), 32'd1);
    chk("dp_held",   32'(bus.dp),   32'(exp_dp));
  endtask

  // Starts a run that is later aborted by a fresh start edge.
  task automatic start_abort(input logic [8:0] n);
    bus.N     = n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    chk("abort_done_low", 32'(bus.done), 32'd0);
    chk("abort_dp_hold",  32'(bus.dp),   32'(exp_dp));
  endtask

  task automatic reset_midrun(input logic [8:0] n);
    bus.N     = n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    #3;
    reset = 1'b1;
    #1;
    chk_zero("rst_mid");
    exp_dp = 9'h000;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) tick();
    chk_zero("rst_after");
  endtask

  initial begin
    logic [8:0] n;
    bus.start = 1'b0;
    bus.N     = 9'h000;
    #2;
    reset = 1'b1;
    #1;
    chk_zero("rst_async");
    @(negedge clock);
    reset = 1'b0;
    repeat (10) tick();
    chk_zero("idle");

    run_check(9'h0FF, 1);
    run_check(9'h0FE, 1);
    run_check(9'h1FE, 2);
    run_check(9'd220, 25);
    run_check(9'd220, 3);
    start_abort(9'h010);
    run_check(9'h010, 1);
    run_check(9'h000, 1);
    reset_midrun(9'h020);
    run_check(9'h020, 1);

    for (int r = 0; r < 8; r++) begin
      n = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 2) == 0) begin
        start_abort({n[8], 8'($urandom_range(0, 200))});
      end
      run_check(n, int'($urandom_range(1, 20)));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
